regfile_ctrl: RTL

REGFILE_CTRL -- requirements
Module: regfile_ctrl

---
 rtl/regfile_ctrl_pkg.sv | 21 ++
 rtl/regfile_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl_pkg.sv
// ============================================================================
// Module   : regfile_ctrl_pkg
// Brief    : Shared widths and state encoding for the register-file controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_ctrl.sv
// ============================================================================
// Module   : regfile_ctrl
// Brief    : 32x32 register file controller over an external dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,

    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,

    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,

    output logic [REG_AW-1:0] ram_ada,
    output logic [REG_AW-1:0] ram_adb,
    output logic [XLEN-1:0]   ram_dina,
    output logic [XLEN-1:0]   ram_dinb,
    output logic              ram_wrea,
    output logic              ram_wreb,
    output logic              ram_cea,
    output logic              ram_ceb,
    output logic              ram_ocea,
    output logic              ram_oceb,
    input  logic [XLEN-1:0]   ram_douta,
    input  logic [XLEN-1:0]   ram_doutb
);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              zero_a_q, zero_a_d;
    logic              zero_b_q, zero_b_d;
    logic [XLEN-1:0]   hold_a_q, hold_a_d;
    logic [XLEN-1:0]   hold_b_q, hold_b_d;

    logic              w_wb_fire;
    logic              w_rd_fire;
    logic              w_rsp_fire;

    assign ram_ocea = 1'b1;
    assign ram_oceb = 1'b1;

    // Strobes and readies are gated by reset so nothing leaks out while it is held.
    assign wb_ready     = !reset && (state_q != ST_INIT);
    assign rd_rsp_valid = (state_q == ST_RSP);
    assign rd_req_ready = !reset && !wb_valid && (state_q != ST_INIT)
                          && (!rd_rsp_valid || rd_rsp_ready);

    assign w_wb_fire  = wb_valid && wb_ready;
    assign w_rd_fire  = rd_req_valid && rd_req_ready;
    assign w_rsp_fire = rd_rsp_valid && rd_rsp_ready;

    // RAM output is only trusted in the first response cycle; afterwards the hold copy is.
    assign rs1_data = zero_a_q ? '0 : (first_q ? ram_douta : hold_a_q);
    assign rs2_data = zero_b_q ? '0 : (first_q ? ram_doutb : hold_b_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = 1'b0;
        zero_a_d = zero_a_q;
        zero_b_d = zero_b_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        ram_ada  = '0;
        ram_adb  = '0;
        ram_dina = '0;
        ram_dinb = '0;
        ram_wrea = 1'b0;
        ram_wreb = 1'b0;
        ram_cea  = 1'b0;
        ram_ceb  = 1'b0;

        if (first_q) begin
            hold_a_d = rs1_data;
            hold_b_d = rs2_data;
        end

        case (state_q)
            ST_INIT: begin
                if (!reset) begin
                    ram_ada  = {cnt_q, 1'b0};
                    ram_adb  = {cnt_q, 1'b1};
                    ram_wrea = 1'b1;
                    ram_wreb = 1'b1;
                    ram_cea  = 1'b1;
                    ram_ceb  = 1'b1;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                if (w_wb_fire) begin
                    // x0 is hardwired; the write is accepted but never reaches the RAM.
                    ram_ada  = wb_rd;
                    ram_dina = wb_data;
                    ram_wrea = (wb_rd != '0);
                    ram_cea  = (wb_rd != '0);
                end else if (w_rd_fire) begin
                    ram_ada = rs1;
                    ram_adb = rs2;
                    ram_cea = 1'b1;
                    ram_ceb = 1'b1;
                end

                if (w_rd_fire) begin
                    state_d  = ST_RSP;
                    first_d  = 1'b1;
                    zero_a_d = (rs1 == '0);
                    zero_b_d = (rs2 == '0);
                end else if (w_rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            zero_a_q <= 1'b0;
            zero_b_q <= 1'b0;
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            zero_a_q <= zero_a_d;
            zero_b_q <= zero_b_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
        end
    end

endmodule

`default_nettype wire
